line_fifo: RTL

Single-clock, parametrised line FIFO for the CNN datapath, buffering one image row (default 720 pixels) between the pixel source and the convolution window. It adds capabilities the basic FIFO lacks: occupancy tracking, full/empty and programmable almost-full/almost-empty flags, and sticky overflow/underflow errors. It also supports a mark/rewind mechanism, so a stored row can be re-read for successive kernel rows without being rewritten. Depth need not be a power of two; pointers wrap explicitly at DEPTH.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/lfifo_ram.sv | 45 ++++
 rtl/line_fifo.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants for the CNN datapath, plus the read-pointer source
// selector used by the line FIFO.
//   LINE_WIDTH_PX   : pixels per image row (default line FIFO depth)
//   PIXEL_WIDTH     : bits per pixel word
//   LINE_ADDR_WIDTH : address bits needed to index one row
// -----------------------------------------------------------------------------
package cnn_pkg;

   localparam int LINE_WIDTH_PX   = 720;
   localparam int PIXEL_WIDTH     = 16;
   localparam int LINE_ADDR_WIDTH = 10;

   // Where the next read pointer comes from, in priority order Clr > Rewind > pop.
   typedef enum logic [1:0] {
      RD_KEEP   = 2'd0,
      RD_POP    = 2'd1,
      RD_REWIND = 2'd2,
      RD_CLR    = 2'd3
   } rd_sel_e;

endpackage : cnn_pkg

// File: rtl/lfifo_ram.sv
// -----------------------------------------------------------------------------
// lfifo_ram
// Simple dual-port storage array for the line FIFO: synchronous write,
// registered read, no reset on the array so it maps onto block RAM.
// Ports:
//   RAM_Clk   : clock, rising edge
//   RAM_Wen   : write enable
//   RAM_Waddr : write address
//   RAM_Wdata : write data
//   RAM_Ren   : read enable (read register only updates when set)
//   RAM_Raddr : read address
//   RAM_Rdata : registered read data, valid the cycle after RAM_Ren
// -----------------------------------------------------------------------------
module lfifo_ram
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = PIXEL_WIDTH,
   parameter int DEPTH      = LINE_WIDTH_PX,
   parameter int ADDR_WIDTH = LINE_ADDR_WIDTH
) (
   input  logic                  RAM_Clk,
   input  logic                  RAM_Wen,
   input  logic [ADDR_WIDTH-1:0] RAM_Waddr,
   input  logic [DATA_WIDTH-1:0] RAM_Wdata,
   input  logic                  RAM_Ren,
   input  logic [ADDR_WIDTH-1:0] RAM_Raddr,
   output logic [DATA_WIDTH-1:0] RAM_Rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_p1;

   // ---- stage p0 -> p1: array write and registered read ----
   always_ff @(posedge RAM_Clk) begin
      if (RAM_Wen) begin
         mem[RAM_Waddr] <= RAM_Wdata;
      end
      if (RAM_Ren) begin
         rd_data_p1 <= mem[RAM_Raddr];
      end
   end

   assign RAM_Rdata = rd_data_p1;

endmodule : lfifo_ram

// File: rtl/line_fifo.sv
// -----------------------------------------------------------------------------
// line_fifo
// Single-clock line buffer between the pixel source and the convolution
// window. Tracks a live count (read->write) and a held count (mark->write);
// a mark/rewind mechanism lets a stored row be re-read without rewriting it.
// Pointers wrap explicitly at DEPTH, so DEPTH need not be a power of two.
// Ports:
//   LFIFO_Clk      : clock, rising edge
//   LFIFO_Rstclr   : asynchronous active-low reset
//   LFIFO_Clr      : synchronous clear (memory contents untouched)
//   LFIFO_Wen      : write request, LFIFO_Data_in written when not Full
//   LFIFO_Ren      : read request; LFIFO_Rdinc=1 pops, 0 peeks
//   LFIFO_Mark     : save read pointer, enter hold mode
//   LFIFO_Rewind   : restore read pointer to the mark (hold mode only)
//   LFIFO_Release  : leave hold mode
//   LFIFO_Data_out : read data, one cycle after an accepted read; 0 otherwise
//   LFIFO_Valid    : LFIFO_Data_out carries a read result
//   LFIFO_Count    : live count
//   LFIFO_Full/Empty/Afull/Aempty : registered status flags
//   LFIFO_Ovf/Udf  : sticky overflow / underflow
// -----------------------------------------------------------------------------
module line_fifo
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH   = PIXEL_WIDTH,
   parameter int DEPTH        = LINE_WIDTH_PX,
   parameter int ADDR_WIDTH   = LINE_ADDR_WIDTH,
   parameter int AFULL_LEVEL  = 704,
   parameter int AEMPTY_LEVEL = 16
) (
   input  logic                  LFIFO_Clk,
   input  logic                  LFIFO_Rstclr,
   input  logic                  LFIFO_Clr,
   input  logic                  LFIFO_Wen,
   input  logic [DATA_WIDTH-1:0] LFIFO_Data_in,
   input  logic                  LFIFO_Ren,
   input  logic                  LFIFO_Rdinc,
   input  logic                  LFIFO_Mark,
   input  logic                  LFIFO_Rewind,
   input  logic                  LFIFO_Release,
   output logic [DATA_WIDTH-1:0] LFIFO_Data_out,
   output logic                  LFIFO_Valid,
   output logic [ADDR_WIDTH:0]   LFIFO_Count,
   output logic                  LFIFO_Full,
   output logic                  LFIFO_Empty,
   output logic                  LFIFO_Afull,
   output logic                  LFIFO_Aempty,
   output logic                  LFIFO_Ovf,
   output logic                  LFIFO_Udf
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // State registers
   logic [ADDR_WIDTH-1:0] wrptr_q, rdptr_q, markptr_q;
   logic [CW-1:0]         cnt_l_q, cnt_h_q;
   logic                  hold_q, ovf_q, udf_q;
   logic                  full_q, empty_q, afull_q, aempty_q;
   logic                  vld_p1;

   // Next-state values
   logic [ADDR_WIDTH-1:0] wrptr_n, rdptr_n, markptr_n;
   logic [CW-1:0]         cnt_l_n, cnt_h_n, wr_c, pop_c;
   logic                  hold_n, ovf_n, udf_n, vld_n;
   logic                  rew_eff, wr_acc, rd_req, rd_acc, pop;
   rd_sel_e               rd_sel;

   logic [DATA_WIDTH-1:0] ram_rdata;

   // ---- stage p0: request acceptance and next-state computation ----
   always_comb begin
      // Full/Empty come from start-of-cycle state: no same-cycle bypass.
      rew_eff = LFIFO_Rewind & hold_q;
      wr_acc  = LFIFO_Wen & ~full_q;
      rd_req  = LFIFO_Ren & ~rew_eff;   // a rewind swallows that cycle's read
      rd_acc  = rd_req & ~empty_q;
      pop     = rd_acc & LFIFO_Rdinc;
      wr_c    = CW'(wr_acc);
      pop_c   = CW'(pop);

      if (LFIFO_Clr)    rd_sel = RD_CLR;
      else if (rew_eff) rd_sel = RD_REWIND;
      else if (pop)     rd_sel = RD_POP;
      else              rd_sel = RD_KEEP;

      case (rd_sel)
         RD_CLR:    rdptr_n = '0;
         RD_REWIND: rdptr_n = markptr_q;
         RD_POP:    rdptr_n = ptr_inc(rdptr_q);
         default:   rdptr_n = rdptr_q;
      endcase

      wrptr_n = wr_acc ? ptr_inc(wrptr_q) : wrptr_q;
      // A rewind makes everything from the mark live again, same-cycle write included.
      cnt_l_n = rew_eff ? (cnt_h_q + wr_c) : (cnt_l_q + wr_c - pop_c);

      hold_n    = hold_q;
      markptr_n = markptr_q;
      cnt_h_n   = cnt_h_q + wr_c;
      if (LFIFO_Mark) begin
         // Mark after a same-cycle rewind captures the rewound (i.e. old mark) pointer;
         // otherwise it captures the pre-pop read pointer, so H ignores this cycle's pop.
         hold_n = 1'b1;
         if (rew_eff) begin
            markptr_n = markptr_q;
            cnt_h_n   = cnt_h_q + wr_c;
         end else begin
            markptr_n = rdptr_q;
            cnt_h_n   = cnt_l_q + wr_c;
         end
      end else if (LFIFO_Release) begin
         hold_n    = 1'b0;
         cnt_h_n   = cnt_l_n;
         markptr_n = rdptr_n;
      end else if (!hold_q) begin
         cnt_h_n   = cnt_l_n;
         markptr_n = rdptr_n;
      end

      ovf_n = ovf_q | (LFIFO_Wen & full_q);
      udf_n = udf_q | (rd_req & empty_q);
      vld_n = rd_acc;

      if (LFIFO_Clr) begin
         wrptr_n   = '0;
         markptr_n = '0;
         cnt_l_n   = '0;
         cnt_h_n   = '0;
         hold_n    = 1'b0;
         ovf_n     = 1'b0;
         udf_n     = 1'b0;
         vld_n     = 1'b0;
      end
   end

   // ---- stage p0 -> p1: state, flags and read-valid registers ----
   always_ff @(posedge LFIFO_Clk or negedge LFIFO_Rstclr) begin
      if (!LFIFO_Rstclr) begin
         wrptr_q   <= '0;
         rdptr_q   <= '0;
         markptr_q <= '0;
         cnt_l_q   <= '0;
         cnt_h_q   <= '0;
         hold_q    <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         afull_q   <= 1'b0;
         aempty_q  <= 1'b1;
         vld_p1    <= 1'b0;
      end else begin
         wrptr_q   <= wrptr_n;
         rdptr_q   <= rdptr_n;
         markptr_q <= markptr_n;
         cnt_l_q   <= cnt_l_n;
         cnt_h_q   <= cnt_h_n;
         hold_q    <= hold_n;
         ovf_q     <= ovf_n;
         udf_q     <= udf_n;
         full_q    <= (cnt_h_n == DEPTH_C);
         empty_q   <= (cnt_l_n == '0);
         afull_q   <= (cnt_h_n >= AFULL_C);
         aempty_q  <= (cnt_l_n <= AEMPTY_C);
         vld_p1    <= vld_n;
      end
   end

   lfifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .RAM_Clk   (LFIFO_Clk),
      .RAM_Wen   (wr_acc & ~LFIFO_Clr),
      .RAM_Waddr (wrptr_q),
      .RAM_Wdata (LFIFO_Data_in),
      .RAM_Ren   (rd_acc & ~LFIFO_Clr),
      .RAM_Raddr (rdptr_q),
      .RAM_Rdata (ram_rdata)
   );

   // ---- stage p1: outputs ----
   assign LFIFO_Data_out = vld_p1 ? ram_rdata : '0;
   assign LFIFO_Valid    = vld_p1;
   assign LFIFO_Count    = cnt_l_q;
   assign LFIFO_Full     = full_q;
   assign LFIFO_Empty    = empty_q;
   assign LFIFO_Afull    = afull_q;
   assign LFIFO_Aempty   = aempty_q;
   assign LFIFO_Ovf      = ovf_q;
   assign LFIFO_Udf      = udf_q;

endmodule : line_fifo
